// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises, debounces and edge-detects seven event sources,
// latches them as pending and presents one one-hot interrupt at a time until eoi.
module irq_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter logic [6:0]  SRC_MASK        = 7'h7F
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        eth_1_int,
   input  logic        eth_2_int,
   input  logic        uart_int,
   input  logic [3:0]  btn,
   input  logic        eoi,
   output logic [31:0] irq,
   output logic [4:0]  irq_id,
   output logic [6:0]  irq_pending
);

   localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACTIVE = 2'd1;
   localparam logic [1:0] S_GAP    = 2'd2;

   logic [6:0]       raw;
   logic [6:0]       sync1;
   logic [6:0]       sync2;
   logic [3:0]       db;
   logic [CNT_W-1:0] cnt [4];
   logic [6:0]       lvl;
   logic [6:0]       lvl_d;
   logic [6:0]       evt;
   logic [6:0]       pending;
   logic [6:0]       clr;
   logic             eoi_d;
   logic             eoi_acc;
   logic [1:0]       state;
   logic [6:0]       irq_q;
   logic [4:0]       irq_id_q;
   logic [2:0]       pick_idx;
   logic [6:0]       pick_oh;

   assign raw = {btn, uart_int, eth_2_int, eth_1_int};

   // Stage: two-flop synchroniser for every source
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Stage: button debounce; the counter only runs while the synchronised level
   // disagrees with the accepted state, so any bounce back restarts the window.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         db <= '0;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2[3+i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_MAX) begin
               db[i]  <= sync2[3+i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
      end
   end

   assign lvl     = {db, sync2[2:0]};
   assign evt     = lvl & ~lvl_d & SRC_MASK;
   assign eoi_acc = eoi & ~eoi_d & (state == S_ACTIVE);
   assign clr     = eoi_acc ? irq_q : 7'h00;

   // Stage: edge detect and pending latch; a same-cycle set beats the eoi clear
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lvl_d   <= '0;
         eoi_d   <= 1'b0;
         pending <= '0;
      end else begin
         lvl_d   <= lvl;
         eoi_d   <= eoi;
         pending <= (pending & ~clr) | evt;
      end
   end

   always_comb begin
      pick_idx = 3'd0;
      pick_oh  = 7'h00;
      for (int i = 6; i >= 0; i--) begin
         if (pending[i]) begin
            pick_idx = 3'(i);
            pick_oh  = 7'h01 << i;
         end
      end
   end

   // Stage: presentation FSM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state    <= S_IDLE;
         irq_q    <= '0;
         irq_id_q <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (|pending) begin
                  irq_q    <= pick_oh;
                  irq_id_q <= {2'b00, pick_idx};
                  state    <= S_ACTIVE;
               end
            end
            S_ACTIVE: begin
               if (eoi_acc) begin
                  irq_q    <= '0;
                  irq_id_q <= '0;
                  state    <= S_GAP;
               end
            end
            S_GAP:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign irq         = {25'd0, irq_q};
   assign irq_id      = irq_id_q;
   assign irq_pending = pending;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: a full-mask instance plus one with the UART source masked off.
module tb_irq_ctrl;

   logic        clk;
   logic        resetn;
   logic        eth_1_int;
   logic        eth_2_int;
   logic        uart_int;
   logic [3:0]  btn;
   logic        eoi;
   logic [31:0] irq;
   logic [4:0]  irq_id;
   logic [6:0]  irq_pending;
   logic [31:0] m_irq;
   logic [4:0]  m_irq_id;
   logic [6:0]  m_irq_pending;

   int checks   = 0;
   int failures = 0;

   irq_ctrl #(.DEBOUNCE_CYCLES(16), .SRC_MASK(7'h7F)) dut (
      .clk(clk), .resetn(resetn), .eth_1_int(eth_1_int), .eth_2_int(eth_2_int),
      .uart_int(uart_int), .btn(btn), .eoi(eoi),
      .irq(irq), .irq_id(irq_id), .irq_pending(irq_pending)
   );

   irq_ctrl #(.DEBOUNCE_CYCLES(16), .SRC_MASK(7'h7B)) dut_m (
      .clk(clk), .resetn(resetn), .eth_1_int(eth_1_int), .eth_2_int(eth_2_int),
      .uart_int(uart_int), .btn(btn), .eoi(eoi),
      .irq(m_irq), .irq_id(m_irq_id), .irq_pending(m_irq_pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_irq(input string tag, input logic [31:0] exp, input int max);
      int n = 0;
      while (irq === 32'h0 && n < max) begin
         @(negedge clk);
         n++;
      end
      chk(tag, irq, exp);
   endtask

   task automatic eoi_pulse();
      eoi = 1'b1;
      step(1);
      eoi = 1'b0;
   endtask

   initial begin
      resetn = 1'b1; eth_1_int = 1'b0; eth_2_int = 1'b0; uart_int = 1'b0;
      btn = 4'h0; eoi = 1'b0;
      #3 resetn = 1'b0;
      step(3);
      chk("rst_irq", irq, 32'h0);
      chk("rst_id", 32'(irq_id), 32'h0);
      chk("rst_pend", 32'(irq_pending), 32'h0);
      resetn = 1'b1;
      step(3);

      // 1: UART pulse of 3 cycles, irq after the 4th edge
      uart_int = 1'b1;
      step(3);
      chk("t1_not_yet", irq, 32'h0);
      uart_int = 1'b0;
      step(1);
      chk("t1_irq", irq, 32'h4);
      chk("t1_id", 32'(irq_id), 32'd2);
      chk("t1_pend", 32'(irq_pending), 32'h4);
      chk("t1_masked", m_irq, 32'h0);
      step(5);
      chk("t1_hold", irq, 32'h4);
      eoi_pulse();
      chk("t1_eoi_irq", irq, 32'h0);
      chk("t1_eoi_id", 32'(irq_id), 32'h0);
      chk("t1_eoi_pend", 32'(irq_pending), 32'h0);
      step(4);

      // 2: eth_2 and uart together, priority then GAP
      eth_2_int = 1'b1; uart_int = 1'b1;
      step(3);
      eth_2_int = 1'b0; uart_int = 1'b0;
      step(1);
      chk("t2_first", irq, 32'h2);
      chk("t2_first_id", 32'(irq_id), 32'd1);
      chk("t2_pend", 32'(irq_pending), 32'h6);
      eoi_pulse();
      chk("t2_eoi_irq", irq, 32'h0);
      chk("t2_eoi_pend", 32'(irq_pending), 32'h4);
      step(1);
      chk("t2_gap", irq, 32'h0);
      step(1);
      chk("t2_second", irq, 32'h4);
      chk("t2_second_id", 32'(irq_id), 32'd2);
      eoi_pulse();
      step(3);
      chk("t2_idle_irq", irq, 32'h0);
      chk("t2_idle_pend", 32'(irq_pending), 32'h0);

      // 4: coalescing and event arriving in the eoi cycle
      eth_1_int = 1'b1;
      step(1);
      eth_1_int = 1'b0;
      step(3);
      chk("t4_irq", irq, 32'h1);
      chk("t4_masked_irq", m_irq, 32'h1);
      eth_1_int = 1'b1;
      step(1);
      eth_1_int = 1'b0;
      step(4);
      chk("t4_coal_pend", 32'(irq_pending), 32'h1);
      chk("t4_coal_irq", irq, 32'h1);
      eoi_pulse();
      step(4);
      chk("t4_cleared_irq", irq, 32'h0);
      chk("t4_cleared_pend", 32'(irq_pending), 32'h0);
      eth_1_int = 1'b1;
      step(1);
      eth_1_int = 1'b0;
      step(3);
      chk("t4_again", irq, 32'h1);
      eth_1_int = 1'b1;
      step(1);
      eth_1_int = 1'b0;
      step(1);
      eoi_pulse();
      chk("t4_setwins_irq", irq, 32'h0);
      chk("t4_setwins_pend", 32'(irq_pending), 32'h1);
      step(1);
      chk("t4_gap", irq, 32'h0);
      step(1);
      chk("t4_reassert", irq, 32'h1);
      eoi_pulse();
      step(3);

      // 5: eoi held high counts once
      eth_1_int = 1'b1; uart_int = 1'b1;
      step(1);
      eth_1_int = 1'b0; uart_int = 1'b0;
      step(3);
      chk("t5_first", irq, 32'h1);
      chk("t5_pend", 32'(irq_pending), 32'h5);
      eoi = 1'b1;
      step(1);
      chk("t5_pend_after", 32'(irq_pending), 32'h4);
      step(19);
      chk("t5_held_irq", irq, 32'h4);
      chk("t5_held_pend", 32'(irq_pending), 32'h4);
      eoi = 1'b0;
      step(2);
      chk("t5_still", irq, 32'h4);
      eoi_pulse();
      chk("t5_done_pend", 32'(irq_pending), 32'h0);
      step(3);

      // 3: bouncing button, one event after the stable window
      for (int b = 0; b < 4; b++) begin
         btn[0] = 1'b1;
         step(10);
         btn[0] = 1'b0;
         step(10);
      end
      chk("t3_bounce_pend", 32'(irq_pending), 32'h0);
      btn[0] = 1'b1;
      step(12);
      chk("t3_early", irq, 32'h0);
      wait_irq("t3_irq", 32'h8, 20);
      chk("t3_id", 32'(irq_id), 32'd3);
      chk("t3_pend", 32'(irq_pending), 32'h8);
      eoi_pulse();
      step(30);
      chk("t3_once", 32'(irq_pending), 32'h0);
      btn[0] = 1'b0;
      step(30);
      chk("t3_fall", 32'(irq_pending), 32'h0);

      // 6: async reset while active, level held through reset
      uart_int = 1'b1;
      step(4);
      chk("t6_active", irq, 32'h4);
      chk("t6_masked", m_irq, 32'h0);
      #2 resetn = 1'b0;
      #1;
      chk("t6_rst_irq", irq, 32'h0);
      chk("t6_rst_id", 32'(irq_id), 32'h0);
      chk("t6_rst_pend", 32'(irq_pending), 32'h0);
      step(3);
      resetn = 1'b1;
      wait_irq("t6_relevel", 32'h4, 8);
      chk("t6_masked_after", m_irq, 32'h0);
      chk("t6_masked_pend", 32'(m_irq_pending), 32'h0);
      uart_int = 1'b0;
      eoi_pulse();
      step(3);
      chk("t6_end", irq, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
